// File: rtl/atari_video_pkg.sv
// Shared constants and pixel types for the TIA-to-VGA video path.
package atari_video_pkg;

    localparam int unsigned TIA_LINE_PIXELS = 160;
    localparam int unsigned TIA_PIX_W       = 7;
    localparam int unsigned VGA_H_VISIBLE   = 640;

    typedef struct packed {
        logic [3:0] hue;
        logic [2:0] luma;
    } tia_pix_s;

    typedef logic [TIA_PIX_W-1:0] tia_pix_t;

endpackage

// File: rtl/line_ram.sv
// One scanline bank: single write port, single registered read port.
module line_ram #(
    parameter int unsigned PIX_W       = 7,
    parameter int unsigned LINE_PIXELS = 160,
    parameter int unsigned AW          = $clog2(LINE_PIXELS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [LINE_PIXELS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scanline_doubler.sv
// Double-buffered TIA line store read twice per line pair by the VGA scan-out.
module scanline_doubler
    import atari_video_pkg::*;
#(
    parameter int unsigned PIX_W       = TIA_PIX_W,
    parameter int unsigned LINE_PIXELS = TIA_LINE_PIXELS,
    parameter int unsigned XSCALE_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_xpos,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             wr_line_end,
    input  logic             rd_line_start,
    input  logic [9:0]       vga_hpos,
    input  logic [9:0]       vga_vpos,
    output logic [PIX_W-1:0] pix_out,
    output logic             pix_valid,
    output logic             overrun,
    output logic [7:0]       underrun_cnt
);

    localparam int unsigned AW = $clog2(LINE_PIXELS);

    logic             wbank;
    logic             rbank;
    logic             ready;
    logic             rbank_ok;
    logic             overrun_q;
    logic [7:0]       underrun_q;

    logic             wr_ok;
    logic             swap_qual;
    logic             swap_go;
    logic             underrun_hit;
    logic [9:0]       rd_addr_full;
    logic [AW-1:0]    rd_addr;
    logic             rd_in_range;

    logic [1:0]       we;
    logic [1:0]       re;
    logic [PIX_W-1:0] rdata0;
    logic [PIX_W-1:0] rdata1;

    logic             rsel_q;
    logic             valid_q;

    logic             unused_bits;

    assign unused_bits = ^vga_vpos[9:1];

    // The read bank is always the one not being written.
    assign rbank = ~wbank;

    assign wr_ok        = wr_en && (32'(wr_xpos) < LINE_PIXELS);
    assign swap_qual    = rd_line_start && !vga_vpos[0];
    // A line completing on the swap cycle is taken as ready and swapped at once.
    assign swap_go      = swap_qual && (ready || wr_line_end);
    assign underrun_hit = swap_qual && !ready && !wr_line_end && rbank_ok;

    assign rd_addr_full = vga_hpos >> XSCALE_LOG2;
    assign rd_addr      = rd_addr_full[AW-1:0];
    assign rd_in_range  = 32'(rd_addr_full) < LINE_PIXELS;

    always_comb begin
        we = '0;
        re = '0;
        we[wbank] = wr_ok;
        re[rbank] = 1'b1;
    end

    line_ram #(
        .PIX_W       (PIX_W),
        .LINE_PIXELS (LINE_PIXELS),
        .AW          (AW)
    ) u_bank0 (
        .clk   (clk),
        .we    (we[0]),
        .waddr (wr_xpos[AW-1:0]),
        .wdata (wr_data),
        .re    (re[0]),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    line_ram #(
        .PIX_W       (PIX_W),
        .LINE_PIXELS (LINE_PIXELS),
        .AW          (AW)
    ) u_bank1 (
        .clk   (clk),
        .we    (we[1]),
        .waddr (wr_xpos[AW-1:0]),
        .wdata (wr_data),
        .re    (re[1]),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbank      <= 1'b0;
            ready      <= 1'b0;
            rbank_ok   <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= '0;
        end else begin
            if (swap_go) begin
                wbank    <= ~wbank;
                ready    <= 1'b0;
                rbank_ok <= 1'b1;
            end else if (wr_line_end) begin
                ready <= 1'b1;
                if (ready) begin
                    overrun_q <= 1'b1;
                end
            end
            if (underrun_hit && (underrun_q != '1)) begin
                underrun_q <= underrun_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsel_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            rsel_q  <= rbank;
            valid_q <= rbank_ok && rd_in_range;
        end
    end

    // RAM data is registered inside the bank; the reset-cleared valid bit gates it
    // so the output drops to zero the instant reset asserts.
    assign pix_out      = valid_q ? (rsel_q ? rdata1 : rdata0) : '0;
    assign pix_valid    = valid_q;
    assign overrun      = overrun_q;
    assign underrun_cnt = underrun_q;

endmodule
